// File: rtl/counter_sel_ctrl.sv
// Front-end controller for counter_3bit: debounces the mode/clear buttons and drives the
// 2-bit sel command, including timed clear bursts after reset and on a clear press.
module counter_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RESET_HOLD      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_clr,
    output logic [1:0] sel,
    output logic [1:0] mode,
    output logic       clr_busy
);

    // state | meaning
    // CLEAR | sel forced to 11 for RESET_HOLD edges; hold_cnt counts the burst
    // RUN   | sel follows mode; a clear press restarts the burst
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(RESET_HOLD + 1);

    // Bit 0 carries the mode button, bit 1 the clear button.
    logic [1:0]    btn;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    db;
    logic [1:0]    db_q;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic [1:0]    mode_nxt;

    assign btn = {btn_clr, btn_mode};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_q <= db;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] != db[i]) begin
                    if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        db[i]     <= ~db[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Only rising edges of the accepted level count; releases are silent.
    assign press = db & ~db_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            hold_cnt <= '0;
            mode     <= 2'b00;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            mode     <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        mode_nxt  = mode;
        if (press[0]) mode_nxt = (mode == 2'b10) ? 2'b00 : mode + 2'b01;
        case (state)
            CLEAR: begin
                hold_nxt = hold_cnt + 1'b1;
                if (hold_cnt == HW'(RESET_HOLD - 1)) state_nxt = RUN;
            end
            RUN: begin
                if (press[1]) begin
                    state_nxt = CLEAR;
                    hold_nxt  = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                hold_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        clr_busy = (state == CLEAR);
        sel      = clr_busy ? 2'b11 : mode;
    end

endmodule

// File: tb/tb_counter_sel_ctrl.sv
// Directed + random bench for counter_sel_ctrl, checked every cycle against a
// window-based behavioural model of debounce, mode cycling and clear bursts.
module tb_counter_sel_ctrl;

    localparam int D = 4;
    localparam int R = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_clr = 1'b0;
    logic [1:0] sel;
    logic [1:0] mode;
    logic       clr_busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    counter_sel_ctrl #(.DEBOUNCE_CYCLES(D), .RESET_HOLD(R)) dut (
        .clk(clk),
        .rst(rst),
        .btn_mode(btn_mode),
        .btn_clr(btn_clr),
        .sel(sel),
        .mode(mode),
        .clr_busy(clr_busy)
    );

    // Model: raw samples per edge; a button level is accepted once the last D
    // synchronised samples (raw delayed two edges) all differ from the accepted level.
    int m_mode;
    int m_left;
    bit m_db [2];
    bit m_pend [2];
    bit hist_m [$];
    bit hist_c [$];

    function automatic void model_reset();
        m_mode = 0;
        m_left = R;
        for (int b = 0; b < 2; b++) begin
            m_db[b]   = 1'b0;
            m_pend[b] = 1'b0;
        end
        hist_m.delete();
        hist_c.delete();
    endfunction

    function automatic bit raw_at(int b, int idx);
        if (idx < 0) return 1'b0;
        return (b == 0) ? hist_m[idx] : hist_c[idx];
    endfunction

    function automatic void model_edge(bit rm, bit rc);
        if (m_pend[0]) m_mode = (m_mode + 1) % 3;
        if (m_left > 0) m_left = m_left - 1;
        else if (m_pend[1]) m_left = R;
        hist_m.push_back(rm);
        hist_c.push_back(rc);
        for (int b = 0; b < 2; b++) begin
            int n;
            bit all;
            n   = (b == 0) ? hist_m.size() : hist_c.size();
            all = 1'b1;
            for (int j = 0; j < D; j++)
                if (raw_at(b, n - 3 - j) == m_db[b]) all = 1'b0;
            m_pend[b] = all && !m_db[b];
            if (all) m_db[b] = ~m_db[b];
        end
    endfunction

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("sel", sel, (m_left > 0) ? 2'b11 : 2'(m_mode));
        check("mode", mode, 2'(m_mode));
        check("clr_busy", {1'b0, clr_busy}, {1'b0, m_left > 0});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(btn_mode, btn_clr);
        #1;
        check_all();
    endtask

    task automatic hold(input bit m, input bit c, input int n);
        btn_mode = m;
        btn_clr  = c;
        repeat (n) tick();
    endtask

    initial begin
        // Reset and power-on clear
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel", sel, 2'b11);
        check("rst_mode", mode, 2'b00);
        check("rst_busy", {1'b0, clr_busy}, 2'b01);
        @(negedge clk);
        rst = 1'b0;
        hold(0, 0, 1);
        check("por_edge1_sel", sel, 2'b11);
        hold(0, 0, 1);
        check("por_edge2_sel", sel, 2'b00);
        hold(0, 0, 4);

        // Single held press: change lands on the 7th edge (E0 + 6)
        hold(1, 0, 6);
        check("press_early", mode, 2'b00);
        hold(1, 0, 1);
        check("press_e0p6", mode, 2'b01);
        hold(1, 0, 3);
        hold(0, 0, 10);
        check("press_hold_once", mode, 2'b01);

        // Mode wrap
        hold(1, 0, 10);
        hold(0, 0, 10);
        check("wrap_10", mode, 2'b10);
        hold(1, 0, 10);
        hold(0, 0, 10);
        check("wrap_00", mode, 2'b00);

        // Glitch and bounce
        hold(1, 0, 3);
        hold(0, 0, 10);
        check("glitch", mode, 2'b00);
        hold(1, 0, 1);
        hold(0, 0, 1);
        hold(1, 0, 1);
        hold(0, 0, 1);
        hold(1, 0, 8);
        hold(0, 0, 10);
        check("bounce", mode, 2'b01);
        hold(1, 0, 10);
        hold(0, 0, 10);

        // Clear in mode 10
        hold(0, 1, 7);
        check("clr_start", sel, 2'b11);
        hold(0, 1, 2);
        check("clr_exit", sel, 2'b10);
        hold(0, 0, 10);

        // Mode press landing one cycle into a clear burst
        hold(0, 1, 1);
        hold(1, 1, 9);
        check("overlap_mode", mode, 2'b00);
        hold(0, 0, 10);
        hold(1, 0, 10);
        hold(0, 0, 10);

        // Async reset between edges, mid-burst
        hold(0, 1, 7);
        #2;
        rst = 1'b1;
        #1;
        check("async_sel", sel, 2'b11);
        check("async_mode", mode, 2'b00);
        check("async_busy", {1'b0, clr_busy}, 2'b01);
        model_reset();
        btn_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold(0, 0, 4);

        // Random segments
        repeat (60) begin
            bit m;
            bit c;
            int len;
            m   = 1'($urandom_range(0, 1));
            c   = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 14);
            hold(m, c, len);
        end
        hold(0, 0, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
